// File: rtl/mmu_arbiter_if.sv
// Bundle of the two requester ports and the MMU command/response port seen by mmu_arbiter.
// slave is the arbiter's view; master is the surrounding CPU/DMA/MMU environment.
interface mmu_arbiter_if;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_wrdata;
  logic [1:0]  i_cpu_size;
  logic [3:0]  i_cpu_cmd;
  logic        i_cpu_usermode;
  logic        i_cpu_valid;
  logic [31:0] o_cpu_rddata;
  logic        o_cpu_done;
  logic [3:0]  o_cpu_error;

  logic [31:0] i_dma_addr;
  logic [31:0] i_dma_wrdata;
  logic [1:0]  i_dma_size;
  logic [3:0]  i_dma_cmd;
  logic        i_dma_usermode;
  logic        i_dma_valid;
  logic [31:0] o_dma_rddata;
  logic        o_dma_done;
  logic [3:0]  o_dma_error;

  logic [31:0] o_mmu_addr;
  logic [31:0] o_mmu_wrdata;
  logic [1:0]  o_mmu_size;
  logic [3:0]  o_mmu_cmd;
  logic        o_mmu_usermode;
  logic        o_mmu_validcmd;
  logic [31:0] i_mmu_rddata;
  logic        i_mmu_rddata_valid;
  logic [3:0]  i_mmu_error;

  logic        o_timeout;

  modport slave (
    input  i_cpu_addr, i_cpu_wrdata, i_cpu_size, i_cpu_cmd, i_cpu_usermode, i_cpu_valid,
    output o_cpu_rddata, o_cpu_done, o_cpu_error,
    input  i_dma_addr, i_dma_wrdata, i_dma_size, i_dma_cmd, i_dma_usermode, i_dma_valid,
    output o_dma_rddata, o_dma_done, o_dma_error,
    output o_mmu_addr, o_mmu_wrdata, o_mmu_size, o_mmu_cmd, o_mmu_usermode, o_mmu_validcmd,
    input  i_mmu_rddata, i_mmu_rddata_valid, i_mmu_error,
    output o_timeout
  );

  modport master (
    output i_cpu_addr, i_cpu_wrdata, i_cpu_size, i_cpu_cmd, i_cpu_usermode, i_cpu_valid,
    input  o_cpu_rddata, o_cpu_done, o_cpu_error,
    output i_dma_addr, i_dma_wrdata, i_dma_size, i_dma_cmd, i_dma_usermode, i_dma_valid,
    input  o_dma_rddata, o_dma_done, o_dma_error,
    input  o_mmu_addr, o_mmu_wrdata, o_mmu_size, o_mmu_cmd, o_mmu_usermode, o_mmu_validcmd,
    output i_mmu_rddata, i_mmu_rddata_valid, i_mmu_error,
    input  o_timeout
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Round-robin CPU/DMA arbiter for the single MMU command port, with per-port request latches
// and a watchdog that force-completes a transaction the MMU never answers.
module mmu_arbiter #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [3:0]  ERR_TIMEOUT = 4'hF
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mmu_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic GntCpu = 1'b0;
  localparam logic GntDma = 1'b1;

  typedef enum logic {StIdle, StWait} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [1:0]  size;
    logic [3:0]  cmd;
    logic        usermode;
  } req_t;

  localparam req_t ReqReset = '{addr: '0, wrdata: '0, size: 2'b11, cmd: '0, usermode: 1'b1};

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cpu_pend_q, cpu_pend_d;
  logic            dma_pend_q, dma_pend_d;
  req_t            cpu_lat_q, cpu_lat_d;
  req_t            dma_lat_q, dma_lat_d;
  req_t            mmu_q, mmu_d;
  logic            validcmd_q, validcmd_d;
  logic            timeout_q, timeout_d;

  req_t cpu_live, dma_live;
  logic cand_cpu, cand_dma, pick, expire, finish, cpu_sel, dma_sel;

  assign cpu_live = '{addr: bus.i_cpu_addr, wrdata: bus.i_cpu_wrdata, size: bus.i_cpu_size,
                      cmd: bus.i_cpu_cmd, usermode: bus.i_cpu_usermode};
  assign dma_live = '{addr: bus.i_dma_addr, wrdata: bus.i_dma_wrdata, size: bus.i_dma_size,
                      cmd: bus.i_dma_cmd, usermode: bus.i_dma_usermode};

  assign cand_cpu = cpu_pend_q | bus.i_cpu_valid;
  assign cand_dma = dma_pend_q | bus.i_dma_valid;

  // cnt_q counts WAIT cycles since the strobe cycle, so expiry lands TIMEOUT cycles after it.
  assign expire = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT)) && !bus.i_mmu_rddata_valid;
  assign finish = bus.i_mmu_rddata_valid | expire;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cpu_pend_d   = cpu_pend_q;
    dma_pend_d   = dma_pend_q;
    cpu_lat_d    = cpu_lat_q;
    dma_lat_d    = dma_lat_q;
    mmu_d        = mmu_q;
    validcmd_d   = validcmd_q;
    timeout_d    = timeout_q;
    pick         = GntCpu;

    if (bus.i_cpu_valid) begin
      cpu_lat_d  = cpu_live;
      cpu_pend_d = 1'b1;
    end
    if (bus.i_dma_valid) begin
      dma_lat_d  = dma_live;
      dma_pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (cand_cpu || cand_dma) begin
          pick = (cand_cpu && cand_dma) ? ~last_grant_q : cand_dma;
          if (pick == GntDma) begin
            mmu_d      = dma_pend_q ? dma_lat_q : dma_live;
            dma_pend_d = 1'b0;
          end else begin
            mmu_d      = cpu_pend_q ? cpu_lat_q : cpu_live;
            cpu_pend_d = 1'b0;
          end
          validcmd_d   = 1'b1;
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          state_d      = StWait;
        end
      end
      StWait: begin
        validcmd_d = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        if (finish) state_d = StIdle;
        if (expire) timeout_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      grant_q      <= GntCpu;
      last_grant_q <= GntDma;
      cnt_q        <= '0;
      cpu_pend_q   <= 1'b0;
      dma_pend_q   <= 1'b0;
      cpu_lat_q    <= '0;
      dma_lat_q    <= '0;
      mmu_q        <= ReqReset;
      validcmd_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cpu_pend_q   <= cpu_pend_d;
      dma_pend_q   <= dma_pend_d;
      cpu_lat_q    <= cpu_lat_d;
      dma_lat_q    <= dma_lat_d;
      mmu_q        <= mmu_d;
      validcmd_q   <= validcmd_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.o_mmu_addr     = mmu_q.addr;
  assign bus.o_mmu_wrdata   = mmu_q.wrdata;
  assign bus.o_mmu_size     = mmu_q.size;
  assign bus.o_mmu_cmd      = mmu_q.cmd;
  assign bus.o_mmu_usermode = mmu_q.usermode;
  assign bus.o_mmu_validcmd = validcmd_q;
  assign bus.o_timeout      = timeout_q;

  // Completion is combinational so done lines up with the MMU response cycle.
  assign cpu_sel = (state_q == StWait) && (grant_q == GntCpu);
  assign dma_sel = (state_q == StWait) && (grant_q == GntDma);

  assign bus.o_cpu_done   = cpu_sel && finish;
  assign bus.o_dma_done   = dma_sel && finish;
  assign bus.o_cpu_rddata = (cpu_sel && !expire) ? bus.i_mmu_rddata : '0;
  assign bus.o_dma_rddata = (dma_sel && !expire) ? bus.i_mmu_rddata : '0;
  assign bus.o_cpu_error  = !cpu_sel ? 4'h0 : (expire ? ERR_TIMEOUT : bus.i_mmu_error);
  assign bus.o_dma_error  = !dma_sel ? 4'h0 : (expire ? ERR_TIMEOUT : bus.i_mmu_error);

endmodule
